// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA controller.
// Optional bus-conflict read-back is enabled by defining OAM_DMA_BUS_CONFLICT_EN.
package oam_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
    localparam logic [15:0] OAM_BASE       = 16'hFE00;
    localparam int          OAM_LEN        = 160;
    localparam logic [7:0]  ECHO_THRESHOLD = 8'hE0;
    localparam logic [15:0] CPU_BUS_TOP    = 16'hFEFF;

    // Sources at E0 and above alias work RAM through the echo region.
    function automatic logic [7:0] eff_src(input logic [7:0] s);
        return (s < ECHO_THRESHOLD) ? s : s - 8'h20;
    endfunction

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Combinational arbiter between the CPU and the DMA engine on the shared bus.
// OAM_DMA_BUS_CONFLICT_EN selects what CPU reads return while DMA owns the bus.
module oam_dma_bus_mux
    import oam_dma_pkg::*;
(
    input  logic        dma_active,
    input  logic        dma_read,
    input  logic [15:0] dma_addr,
    input  logic        cpu_en,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    logic cpu_sel;
    assign cpu_sel = cpu_en && cpu_req && (cpu_addr <= CPU_BUS_TOP);

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        // While DMA owns the bus the CPU is ignored entirely, writes included.
        if (dma_active) begin
            if (dma_read) begin
                mem_req  = 1'b1;
                mem_addr = dma_addr;
            end
        end else if (cpu_sel) begin
            mem_req   = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

`ifdef OAM_DMA_BUS_CONFLICT_EN
    assign cpu_rdata = mem_rdata;
`else
    assign cpu_rdata = dma_active ? 8'hFF : mem_rdata;
`endif

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: FF46 write copies 160 bytes from {src,00} into OAM.
// Define OAM_DMA_BUS_CONFLICT_EN to return live bus data to CPU reads during DMA.
module oam_dma_ctrl
    import oam_dma_pkg::*;
#(
    parameter int START_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wr_en,
    input  logic        reg_rd_en,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        dma_active
);

    localparam logic [7:0] DLY_LAST = 8'(START_DELAY - 1);
    localparam logic [7:0] IDX_LAST = 8'(OAM_LEN - 1);
    localparam dma_state_e START_ST = (START_DELAY == 0) ? ST_READ : ST_DELAY;

    dma_state_e state;
    logic [7:0] src;
    logic [7:0] idx;
    logic [7:0] dly_cnt;
    logic       reg_hit_wr;

    assign reg_hit_wr = reg_wr_en && (reg_addr == DMA_REG_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            src     <= 8'h00;
            idx     <= 8'h00;
            dly_cnt <= 8'h00;
        end else if (reg_hit_wr) begin
            // A new trigger always wins, even over the final byte.
            src     <= reg_wdata;
            idx     <= 8'h00;
            dly_cnt <= 8'h00;
            state   <= START_ST;
        end else begin
            case (state)
                ST_DELAY: begin
                    dly_cnt <= dly_cnt + 8'd1;
                    if (dly_cnt == DLY_LAST)
                        state <= ST_READ;
                end
                ST_READ:
                    state <= ST_WRITE;
                ST_WRITE: begin
                    if (idx == IDX_LAST) begin
                        idx   <= 8'h00;
                        state <= ST_IDLE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= ST_READ;
                    end
                end
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

    assign reg_rdata  = (reg_rd_en && (reg_addr == DMA_REG_ADDR)) ? src : 8'hFF;
    assign dma_active = (state == ST_READ) || (state == ST_WRITE);
    assign oam_we     = (state == ST_WRITE);
    assign oam_addr   = oam_we ? idx : 8'h00;
    assign oam_wdata  = oam_we ? mem_rdata : 8'h00;

    oam_dma_bus_mux u_bus_mux (
        .dma_active (dma_active),
        .dma_read   (state == ST_READ),
        .dma_addr   ({eff_src(src), idx}),
        .cpu_en     (!reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 Parameter: START_DELAY, default 4, number of clk cycles between the FF46 write and the first source read.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 reg_wr_en / reg_rd_en  in  1 each  CPU register write / read strobe.
REQ-005 reg_addr  in  16  CPU register address; only 16'hFF46 is decoded.
REQ-006 reg_wdata  in  8 / reg_rdata  out  8  register write / read data.
REQ-007 cpu_req / cpu_we  in  1 each  CPU memory request and write flag; covers 16'h0000-16'hFEFF only.
REQ-008 cpu_addr  in  16 / cpu_wdata  in  8 / cpu_rdata  out  8  CPU memory address, write data and read data.
REQ-009 mem_req / mem_we  out  1 each  shared memory-bus request and write flag.
REQ-010 mem_addr  out  16 / mem_wdata  out  8  shared-bus address and write data.
REQ-011 mem_rdata  in  8  shared-bus read data; valid one cycle after a read request.
REQ-012 oam_we  out  1 / oam_addr  out  8 / oam_wdata  out  8  OAM write port (byte offset from FE00).
REQ-013 dma_active  out  1  high in states READ and WRITE.

Function
REQ-014 States: IDLE, DELAY, READ, WRITE; index register idx[7:0]; source register src[7:0].
REQ-015 reg_wr_en with reg_addr==FF46: src<=reg_wdata, idx<=0, delay counter<=0, state<=DELAY; this applies from any state, so a write during an active transfer restarts the transfer.
REQ-016 A register write takes priority over every other transition in the same cycle, including completion at idx 159.
REQ-017 reg_rd_en with reg_addr==FF46 returns src combinationally; any other register read returns 8'hFF.
REQ-018 DELAY: the counter increments each cycle; when it reaches START_DELAY-1 the next state is READ; START_DELAY==0 goes directly to READ.
REQ-019 READ: mem_req=1, mem_we=0, mem_addr={eff_src, idx}; next state is WRITE.
REQ-020 eff_src = src when src<8'hE0, otherwise src-8'h20 (echo mapping).
REQ-021 WRITE: oam_we=1, oam_addr=idx, oam_wdata=mem_rdata; mem_req=0.
REQ-022 WRITE at idx<159: idx+1, next state READ.
REQ-023 WRITE at idx==159: idx<=0, next state IDLE.
REQ-024 A full transfer is 160 bytes in exactly 320 cycles after DELAY; idx never exceeds 159.
REQ-025 IDLE and DELAY: mem_* follow cpu_* combinationally (mem_req=cpu_req) and cpu_rdata=mem_rdata; oam_we=0.
REQ-026 READ and WRITE: CPU writes are dropped and never reach mem_* or OAM.
REQ-027 READ and WRITE: CPU read data per REQ-030.
REQ-028 When no path drives the memory bus, mem_addr=0 and mem_wdata=0.

Reset
REQ-029 Reset asserted, at any time including mid-transfer: state=IDLE, src=0, idx=0, delay counter=0, dma_active=0, oam_we=0, mem_req=0, mem_we=0, oam_addr=0, oam_wdata=0; reset completes no partial byte.

Configuration
REQ-030 Macro OAM_DMA_BUS_CONFLICT_EN: when defined, CPU reads while dma_active return the byte currently on mem_rdata (bus-conflict emulation); when undefined, they return 8'hFF.

Structure
REQ-031 Package oam_dma_pkg holds: the state enum, DMA_REG_ADDR=16'hFF46, OAM_BASE=16'hFE00, OAM_LEN=160, ECHO_THRESHOLD=8'hE0.
REQ-032 One combinational sub-module, oam_dma_bus_mux, selects the CPU or DMA onto mem_* and generates cpu_rdata; the FSM and counters stay in oam_dma_ctrl.

Verification
REQ-033 Write FF46=8'hC1 with C100..C19F preloaded with i^8'h5A -> after 4 + 320 cycles OAM[i]=i^8'h5A for i=0..159; dma_active is high for exactly 320 cycles.
REQ-034 Write FF46=8'hFE -> READ cycles drive mem_addr DE00..DE9F.
REQ-035 Write FF46=8'hC0 and read FF46 -> returns 8'hC0; read FF47 -> returns 8'hFF.
REQ-036 At idx=80, write FF46=8'hD0 -> DELAY re-entered, idx=0, the next read is D000, and 160 further bytes are written.
REQ-037 During a transfer, CPU write to C000 -> no mem_we asserted; CPU read returns 8'hFF, or the current mem_rdata with OAM_DMA_BUS_CONFLICT_EN defined.
REQ-038 Assert reset at idx=50 -> all outputs zero, state IDLE; no oam_we until the next FF46 write.
